// File: rtl/seg_scan.sv
// seg_scan: self-timed multi-digit 7-segment scan driver.
//
// Owns the digit refresh prescaler. Display data is double-buffered: a load
// strobe captures value/dp/blank into a pending register, and the pending data
// moves into the displayed (shadow) register only at a frame boundary. Every
// digit slot starts with a guard interval with all anodes off to avoid ghosting.
//
// Parameters:
//   NUM_DIGITS   digits scanned (1..8)
//   REFRESH_DIV  clock cycles per digit slot (>= 4)
//   GUARD        cycles at the start of each slot with all anodes off
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous active-high reset
//   i_value        packed nibbles, digit 0 = i_value[3:0] (rightmost)
//   i_dp_in        decimal point request per digit, active high
//   i_blank        force digit dark, active high
//   i_load         one-cycle strobe capturing value/dp_in/blank
//   o_seg          segments {g,f,e,d,c,b,a}, active low
//   o_dp_n         decimal point, active low
//   o_an           anode enables, active low
//   o_frame_done   one-cycle pulse when a new frame's data becomes active
//
// Build option: define SEG_SCAN_LZB_EN to enable leading-zero blanking.

module seg_scan #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GUARD       = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [4*NUM_DIGITS-1:0]   i_value,
    input  logic [NUM_DIGITS-1:0]     i_dp_in,
    input  logic [NUM_DIGITS-1:0]     i_blank,
    input  logic                      i_load,
    output logic [6:0]                o_seg,
    output logic                      o_dp_n,
    output logic [NUM_DIGITS-1:0]     o_an,
    output logic                      o_frame_done
);

    localparam int unsigned P_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned I_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned V_W = 4 * NUM_DIGITS;

    localparam logic [P_W-1:0] P_LAST  = P_W'(REFRESH_DIV - 1);
    localparam logic [P_W-1:0] P_GUARD = P_W'(GUARD);
    localparam logic [I_W-1:0] I_LAST  = I_W'(NUM_DIGITS - 1);

    // Slot phases, derived from the prescaler
    localparam logic [0:0] ST_GUARD = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [P_W-1:0]        r_presc;
    logic [I_W-1:0]        r_digit;

    logic [V_W-1:0]        r_pd_value;
    logic [NUM_DIGITS-1:0] r_pd_dp;
    logic [NUM_DIGITS-1:0] r_pd_blank;
    logic                  r_pd_valid;

    logic [V_W-1:0]        r_sh_value;
    logic [NUM_DIGITS-1:0] r_sh_dp;
    logic [NUM_DIGITS-1:0] r_sh_blank;

    logic [6:0]            r_seg;
    logic                  r_dp_n;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_frame_done;

    logic                  w_boundary;
    logic [0:0]            w_phase;
    logic [3:0]            w_nib;
    logic                  w_dp_sel;
    logic                  w_dark;
    logic [NUM_DIGITS-1:0] w_lzb;
    logic [6:0]            w_seg;
    logic                  w_dp_n;
    logic [NUM_DIGITS-1:0] w_an;

    // Hex to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign w_boundary = (r_presc == P_LAST) && (r_digit == I_LAST);

    // Prescaler and digit index
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_presc <= '0;
            r_digit <= '0;
        end else if (r_presc == P_LAST) begin
            r_presc <= '0;
            r_digit <= (r_digit == I_LAST) ? '0 : r_digit + I_W'(1);
        end else begin
            r_presc <= r_presc + P_W'(1);
        end
    end

    // Pending register; valid clears at every frame boundary
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pd_value <= '0;
            r_pd_dp    <= '0;
            r_pd_blank <= '0;
            r_pd_valid <= 1'b0;
        end else begin
            if (i_load) begin
                r_pd_value <= i_value;
                r_pd_dp    <= i_dp_in;
                r_pd_blank <= i_blank;
            end
            if (w_boundary) begin
                r_pd_valid <= 1'b0;
            end else if (i_load) begin
                r_pd_valid <= 1'b1;
            end
        end
    end

    // Shadow register; a load on the boundary cycle bypasses the pending stage
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sh_value <= '0;
            r_sh_dp    <= '0;
            r_sh_blank <= '0;
        end else if (w_boundary) begin
            if (i_load) begin
                r_sh_value <= i_value;
                r_sh_dp    <= i_dp_in;
                r_sh_blank <= i_blank;
            end else if (r_pd_valid) begin
                r_sh_value <= r_pd_value;
                r_sh_dp    <= r_pd_dp;
                r_sh_blank <= r_pd_blank;
            end
        end
    end

    // Current digit's nibble and dp from the shadow register
    always_comb begin
        w_nib    = 4'h0;
        w_dp_sel = 1'b0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (r_digit == I_W'(k)) begin
                w_nib    = r_sh_value[4*k +: 4];
                w_dp_sel = r_sh_dp[k];
            end
        end
    end

`ifdef SEG_SCAN_LZB_EN
    // Digit k>0 goes dark while it and every higher digit is zero with no dp
    always_comb begin
        logic run;
        w_lzb = '0;
        run   = 1'b1;
        for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
            run      = run & (r_sh_value[4*k +: 4] == 4'h0) & ~r_sh_dp[k];
            w_lzb[k] = run;
        end
    end
`else
    assign w_lzb = '0;
`endif

    // Slot phase, darkness and next output values
    always_comb begin
        w_phase = (r_presc >= P_GUARD) ? ST_DRIVE : ST_GUARD;
        w_dark  = 1'b0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (r_digit == I_W'(k)) begin
                w_dark = r_sh_blank[k] | w_lzb[k];
            end
        end
        w_seg  = 7'h7F;
        w_dp_n = 1'b1;
        w_an   = '1;
        if (w_phase == ST_DRIVE && !w_dark) begin
            w_seg  = f_decode(w_nib);
            w_dp_n = ~w_dp_sel;
            for (int k = 0; k < int'(NUM_DIGITS); k++) begin
                w_an[k] = (r_digit != I_W'(k));
            end
        end
    end

    // Output registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_seg        <= 7'h7F;
            r_dp_n       <= 1'b1;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= w_seg;
            r_dp_n       <= w_dp_n;
            r_an         <= w_an;
            r_frame_done <= w_boundary;
        end
    end

    assign o_seg        = r_seg;
    assign o_dp_n       = r_dp_n;
    assign o_an         = r_an;
    assign o_frame_done = r_frame_done;

endmodule
